// File: rtl/semaforo_pkg.sv
// Shared types and defaults for the pedestrian push-button conditioner.
// Holds the FSM state encoding, default timing constants and the saturating counter step.
package semaforo_pkg;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRANDO     = 3'd1,
    PENDENTE      = 3'd2,
    BLOQUEIO      = 3'd3,
    ESPERA_SOLTAR = 3'd4
  } cond_estado_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned LOCKOUT_CYCLES_DEF  = 8;
  localparam int unsigned CNT_W               = 8;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reusable for any asynchronous input; both stages clear on reset.
module sincronizador_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/condicionador_botao.sv
// Pedestrian push-button conditioner: synchronize, debounce, hold the request
// until serviced, then lock out further presses until the button is released.
module condicionador_botao
  import semaforo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic botao_bruto,
  input  logic atendido,
  output logic pedido,
  output logic pedido_pulso,
  output logic bloqueado
);

  localparam logic [CNT_W-1:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = 8'(LOCKOUT_CYCLES);

  logic             w_s;
  cond_estado_t     r_estado;
  cond_estado_t     w_estado_prox;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_prox;
  logic             r_pedido;
  logic             r_pedido_pulso;
  logic             r_bloqueado;

  sincronizador_2ff u_sinc (
    .clk   (clk),
    .reset (reset),
    .d     (botao_bruto),
    .q     (w_s)
  );

  // State and shared counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
      r_cnt    <= 8'd0;
    end else begin
      r_estado <= w_estado_prox;
      r_cnt    <= w_cnt_prox;
    end
  end

  // Next-state and counter logic; atendido only matters while a request is pending.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    case (r_estado)
      OCIOSO: begin
        if (w_s) begin
          w_estado_prox = FILTRANDO;
          w_cnt_prox    = 8'd1;
        end else begin
          w_estado_prox = OCIOSO;
        end
      end
      FILTRANDO: begin
        if (!w_s) begin
          w_estado_prox = OCIOSO;
          w_cnt_prox    = 8'd0;
        end else if (r_cnt == DEB_LAST) begin
          w_estado_prox = PENDENTE;
          w_cnt_prox    = 8'd0;
        end else begin
          w_cnt_prox    = cnt_inc(r_cnt);
        end
      end
      PENDENTE: begin
        if (atendido) begin
          w_estado_prox = BLOQUEIO;
          w_cnt_prox    = 8'd1;
        end else begin
          w_estado_prox = PENDENTE;
        end
      end
      BLOQUEIO: begin
        if (r_cnt == LOCK_LAST) begin
          w_estado_prox = w_s ? ESPERA_SOLTAR : OCIOSO;
          w_cnt_prox    = 8'd0;
        end else begin
          w_cnt_prox    = cnt_inc(r_cnt);
        end
      end
      ESPERA_SOLTAR: begin
        if (!w_s) begin
          w_estado_prox = OCIOSO;
        end else begin
          w_estado_prox = ESPERA_SOLTAR;
        end
      end
      default: begin
        w_estado_prox = OCIOSO;
        w_cnt_prox    = 8'd0;
      end
    endcase
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pedido       <= 1'b0;
      r_pedido_pulso <= 1'b0;
      r_bloqueado    <= 1'b0;
    end else begin
      r_pedido       <= (w_estado_prox == PENDENTE);
      r_pedido_pulso <= (w_estado_prox == PENDENTE) && (r_estado != PENDENTE);
      r_bloqueado    <= (w_estado_prox == BLOQUEIO) || (w_estado_prox == ESPERA_SOLTAR);
    end
  end

  assign pedido       = r_pedido;
  assign pedido_pulso = r_pedido_pulso;
  assign bloqueado    = r_bloqueado;

endmodule

// File: tb/tb_condicionador_botao.sv
// Directed bench for condicionador_botao with default timing (debounce 4, lockout 8).
module tb_condicionador_botao;

  logic clk;
  logic reset;
  logic botao_bruto;
  logic atendido;
  logic pedido;
  logic pedido_pulso;
  logic bloqueado;

  int n_cmp;
  int n_err;

  condicionador_botao dut (
    .clk          (clk),
    .reset        (reset),
    .botao_bruto  (botao_bruto),
    .atendido     (atendido),
    .pedido       (pedido),
    .pedido_pulso (pedido_pulso),
    .bloqueado    (bloqueado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic p, input logic pp, input logic b);
    chk({tag, ".pedido"}, pedido, p);
    chk({tag, ".pulso"}, pedido_pulso, pp);
    chk({tag, ".bloq"}, bloqueado, b);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b0;
    botao_bruto = 1'b0;
    atendido    = 1'b0;

    // Reset state
    step(2);
    chk_all("rst", 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    step(3);
    chk_all("idle", 1'b0, 1'b0, 1'b0);

    // Clean press held 10 cycles: pedido after edge k+5
    botao_bruto = 1'b1;
    step(5);
    chk_all("press_k4", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("press_k5", 1'b1, 1'b1, 1'b0);
    step(1);
    chk_all("press_k6", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_all("press_hold", 1'b1, 1'b0, 1'b0);
    end
    botao_bruto = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk_all("pend_wait", 1'b1, 1'b0, 1'b0);
    end

    // Service: pedido falls and bloqueado rises on the same edge, lasts 8 cycles
    atendido = 1'b1;
    step(1);
    atendido = 1'b0;
    chk_all("serv_e0", 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step(1);
      chk_all("lock", 1'b0, 1'b0, 1'b1);
    end
    step(1);
    chk_all("lock_end", 1'b0, 1'b0, 1'b0);

    // Bounce 1,1,0,1,1,1,0 never produces a request
    begin
      logic [6:0] pat;
      pat = 7'b1101110;
      for (int i = 6; i >= 0; i--) begin
        botao_bruto = pat[i];
        step(1);
        chk("bounce.pedido", pedido, 1'b0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bounce_tail.pedido", pedido, 1'b0);
    end

    // atendido in OCIOSO is ignored
    atendido = 1'b1;
    step(1);
    atendido = 1'b0;
    step(2);
    chk_all("att_idle", 1'b0, 1'b0, 1'b0);

    // Button held through service and lockout
    botao_bruto = 1'b1;
    step(6);
    chk_all("held_req", 1'b1, 1'b1, 1'b0);
    atendido = 1'b1;
    step(1);
    atendido = 1'b0;
    chk_all("held_serv", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1);
      chk_all("held_wait", 1'b0, 1'b0, 1'b1);
    end
    botao_bruto = 1'b0;
    step(2);
    chk_all("rel_r1", 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("rel_r2", 1'b0, 1'b0, 1'b0);
    step(1);
    botao_bruto = 1'b1;
    step(5);
    chk_all("repress_k4", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("repress_k5", 1'b1, 1'b1, 1'b0);

    // atendido together with a new press in PENDENTE: atendido wins
    botao_bruto = 1'b0;
    step(4);
    chk_all("pend_rel", 1'b1, 1'b0, 1'b0);
    atendido    = 1'b1;
    botao_bruto = 1'b1;
    step(1);
    atendido = 1'b0;
    chk_all("att_press_e0", 1'b0, 1'b0, 1'b1);
    step(2);
    botao_bruto = 1'b0;
    for (int i = 3; i < 8; i++) begin
      step(1);
      chk_all("att_press_lock", 1'b0, 1'b0, 1'b1);
    end
    step(1);
    chk_all("att_press_end", 1'b0, 1'b0, 1'b0);
    step(6);
    chk("att_press_discard.pedido", pedido, 1'b0);

    // Reset mid-FILTRANDO, then re-debounce with button held
    botao_bruto = 1'b1;
    step(3);
    reset = 1'b0;
    #2;
    chk_all("rst_filt", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(5);
    chk_all("rst_filt_k4", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("rst_filt_k5", 1'b1, 1'b1, 1'b0);

    // Reset mid-BLOQUEIO clears outputs without a clock edge
    atendido = 1'b1;
    step(1);
    atendido = 1'b0;
    step(3);
    chk_all("pre_rst_lock", 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #2;
    chk_all("rst_lock", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(5);
    chk_all("rst_lock_k4", 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("rst_lock_k5", 1'b1, 1'b1, 1'b0);
    botao_bruto = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
